display_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 8-digit seven-segment display. Drives the 3-bit select of the 8:1 four-bit digit multiplexer (`sel`) and the active-low digit anodes so each digit is lit in turn at a fixed refresh rate. An optional anti-ghosting guard interval blanks the display while the select changes. Sits between the digit-value registers/multiplexer and the segment decoder/board pins.

---
 rtl/display_scan_pkg.sv | 17 +
 rtl/display_scan_ctrl_slot_timer.sv | 42 ++++
 rtl/display_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/display_scan_pkg.sv
// Shared types and sizing helpers for the seven-segment scan controller.
package display_scan_pkg;

    localparam int N_DIGITS = 8;
    localparam int SEL_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_ON
    } scan_state_t;

    function automatic int CNT_W(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// Slot prescaler: counts 0..CLK_DIV-1 and flags the last guard and last slot cycles.
module slot_timer
    import display_scan_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    output logic [CNT_W(CLK_DIV)-1:0]   cnt,
    output logic                        slot_end,
    output logic                        guard_end
);

    localparam int            W          = CNT_W(CLK_DIV);
    localparam logic [W-1:0]  SLOT_LAST  = W'(CLK_DIV - 1);
    localparam logic [W-1:0]  GUARD_LAST = W'(GUARD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || slot_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign slot_end  = (cnt_q == SLOT_LAST);
    assign guard_end = (cnt_q == GUARD_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit time-multiplexed display scanner driving mux select and active-low anodes.
// Optional anti-ghosting blank interval at each slot start is enabled by SCAN_GUARD_EN.
module display_scan_ctrl
    import display_scan_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_DIGITS-1:0]   digit_mask,
    output logic [SEL_W-1:0]      sel,
    output logic [N_DIGITS-1:0]   an,
    output logic                  blank,
    output logic                  frame_tick
);

    scan_state_t          state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     next_sel;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic                 blank_q, blank_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 lit_q, lit_d;

    logic                        timer_clr;
    logic                        slot_end;
    logic                        guard_end;
    logic [CNT_W(CLK_DIV)-1:0]   unused_cnt;
`ifndef SCAN_GUARD_EN
    logic                        unused_guard_end;
    assign unused_guard_end = guard_end;
`endif

    // Hold the counter at zero while idle so the first slot starts at cnt = 0.
    assign timer_clr = !en || (state_q == ST_IDLE);

    slot_timer #(
        .CLK_DIV (CLK_DIV),
        .GUARD   (GUARD)
    ) u_slot_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .cnt       (unused_cnt),
        .slot_end  (slot_end),
        .guard_end (guard_end)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        lit_d        = lit_q;
        an_d         = '1;
        blank_d      = 1'b1;
        frame_tick_d = 1'b0;
        next_sel     = sel_q + SEL_W'(1);

        if (!en) begin
            state_d = ST_IDLE;
            sel_d   = '0;
            lit_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    sel_d        = '0;
                    frame_tick_d = 1'b1;
`ifdef SCAN_GUARD_EN
                    state_d      = ST_GUARD;
`else
                    state_d      = ST_ON;
                    lit_d        = digit_mask[0];
                    an_d[0]      = ~digit_mask[0];
                    blank_d      = ~digit_mask[0];
`endif
                end
`ifdef SCAN_GUARD_EN
                ST_GUARD: begin
                    if (guard_end) begin
                        state_d     = ST_ON;
                        lit_d       = digit_mask[sel_q];
                        an_d[sel_q] = ~digit_mask[sel_q];
                        blank_d     = ~digit_mask[sel_q];
                    end
                end
`endif
                ST_ON: begin
                    if (slot_end) begin
                        sel_d        = next_sel;
                        frame_tick_d = (next_sel == '0);
`ifdef SCAN_GUARD_EN
                        state_d      = ST_GUARD;
`else
                        // Mask bit for the new digit is taken on its first cycle.
                        lit_d          = digit_mask[next_sel];
                        an_d[next_sel] = ~digit_mask[next_sel];
                        blank_d        = ~digit_mask[next_sel];
`endif
                    end else begin
                        an_d[sel_q] = ~lit_q;
                        blank_d     = ~lit_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            an_q         <= '1;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            lit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            an_q         <= an_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
            lit_q        <= lit_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a time-based reference model predicts every output cycle.
module tb_display_scan_ctrl;

    localparam int CD = 8;
    localparam int G  = 2;
`ifdef SCAN_GUARD_EN
    localparam int GB = G;
`else
    localparam int GB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] digit_mask = 8'hFF;
    logic [2:0] sel;
    logic [7:0] an;
    logic       blank;
    logic       frame_tick;

    display_scan_ctrl #(
        .CLK_DIV (CD),
        .GUARD   (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel),
        .an         (an),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] an;
        logic       blank;
        logic       ft;
    } obs_t;

    localparam obs_t IDLE_OBS = '{sel: 3'd0, an: 8'hFF, blank: 1'b1, ft: 1'b0};

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model: t counts cycles since enable; slot and position follow by division.
    bit   act = 1'b0;
    int   t = 0;
    logic lit_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        obs_t e;
        int   slot;
        int   pos;
        if (!rst_n) begin
            act = 1'b0;
            if (exp_q.size() == 0) exp_q.push_back(IDLE_OBS);
            else exp_q[exp_q.size() - 1] = IDLE_OBS;
        end else if (!en) begin
            act = 1'b0;
            exp_q.push_back(IDLE_OBS);
        end else begin
            if (!act) begin
                act = 1'b1;
                t = 0;
            end else begin
                t++;
            end
            slot = (t / CD) % 8;
            pos  = t % CD;
            if (pos == GB) lit_m = digit_mask[slot];
            e.sel = slot[2:0];
            e.ft  = ((t % (8 * CD)) == 0);
            e.an  = 8'hFF;
            if (pos < GB) begin
                e.blank = 1'b1;
            end else begin
                e.an[slot] = ~lit_m;
                e.blank    = ~lit_m;
            end
            exp_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        obs_t a;
        obs_t e;
        a = {sel, an, blank, frame_tick};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got sel=%0d an=%h", $time, sel, an);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs at %0t: sel=%0d/%0d an=%h/%h blank=%b/%b frame_tick=%b/%b (got/required)",
                         $time, a.sel, e.sel, a.an, e.an, a.blank, e.blank, a.ft, e.ft);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sel(input logic [2:0] s, input bit need_lit);
        int k = 0;
        while (!(sel == s && (!need_lit || an != 8'hFF)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL wait_sel timeout: sel=%0d an=%h, required sel=%0d lit=%0b", sel, an, s, need_lit);
        end
    endtask

    initial begin
        // Reset held, then idle with scan disabled.
        cyc(3);
        rst_n = 1'b1;
        cyc(50);

        // Full frames, all digits enabled.
        en = 1'b1;
        digit_mask = 8'hFF;
        cyc(70);

        // Sparse mask.
        digit_mask = 8'b1010_0101;
        cyc(70);

        // Clear digit 3 while it is lit: effective only from its next slot.
        digit_mask = 8'hFF;
        wait_sel(3'd3, 1'b1);
        cyc(2);
        digit_mask = 8'hF7;
        cyc(80);

        // Disable mid-scan at sel = 5, cnt = 4, then restart.
        digit_mask = 8'hFF;
        wait_sel(3'd5, 1'b0);
        cyc(4);
        en = 1'b0;
        cyc(5);
        en = 1'b1;
        cyc(20);

        // Randomized enable drops and mask changes.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                en = 1'b0;
                cyc($urandom_range(1, 4));
                en = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) digit_mask = 8'($urandom);
        end

        // Asynchronous reset pulse between edges while a digit is lit.
        digit_mask = 8'hFF;
        wait_sel(3'd2, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sel, an, blank, frame_tick} !== {3'd0, 8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: sel=%0d an=%h blank=%b frame_tick=%b, required 0 ff 1 0",
                     sel, an, blank, frame_tick);
        end
        #1 rst_n = 1'b1;
        cyc(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
